// File: rtl/blake2_host.sv
// blake2_host: feeds a config byte and a message stream into the BLAKE2 core over its
// valid/ready byte pins, then captures the emitted hash bytes into a random-access buffer.
module blake2_host #(
    parameter int  HASH_BYTES = 32,
    parameter int  TIMEOUT    = 4096,
    localparam int AW         = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start_i,
    input  logic [7:0]    cfg_i,
    input  logic          src_valid_i,
    input  logic [7:0]    src_data_i,
    input  logic          src_last_i,
    output logic          src_ready_o,
    output logic [7:0]    ui_in_o,
    output logic [2:0]    uio_in_o,
    input  logic [7:0]    uo_out_i,
    input  logic [7:0]    uio_out_i,
    input  logic [7:0]    uio_oe_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o
);
    localparam int SW = $clog2(TIMEOUT);

    // state | meaning
    // IDLE  | no transaction since reset
    // CFG   | config byte presented (uio_in = start|valid)
    // DATA  | streaming message bytes through the one-byte output slot
    // WAIT  | message done, waiting for first hash byte
    // CAP   | capturing hash bytes
    // DONE  | all hash bytes captured
    // ERR   | stall limit reached, transaction aborted
    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_DATA, S_WAIT, S_CAP, S_DONE, S_ERR
    } state_t;

    state_t          r_state;
    logic [7:0]      r_ui;
    logic [2:0]      r_uio;
    logic [AW-1:0]   r_idx;
    logic [SW-1:0]   r_stall;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;
    logic [7:0]      r_buf [HASH_BYTES];

    logic w_ready;
    logic w_hvalid;
    logic w_xfer;
    logic w_src_hs;
    logic w_cap;
    logic w_stall;
    logic w_tc;
    logic w_unused;

    assign w_ready  = uio_out_i[3] & uio_oe_i[3];
    assign w_hvalid = uio_out_i[7] & uio_oe_i[7];
    assign w_xfer   = r_uio[0] & w_ready;
    assign w_unused = &{1'b0, uio_out_i[6:4], uio_out_i[2:0], uio_oe_i[6:4], uio_oe_i[2:0]};

    // CFG accepts upstream too, so the first message byte follows the config byte with no bubble
    assign src_ready_o = ((r_state == S_CFG) || (r_state == S_DATA))
                       & (~r_uio[0] | w_ready) & ~r_uio[2];
    assign w_src_hs    = src_valid_i & src_ready_o;
    assign w_cap       = ((r_state == S_WAIT) || (r_state == S_CAP)) & w_hvalid;
    assign w_tc        = (r_stall == SW'(TIMEOUT - 1));

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_CFG:          w_stall = r_uio[0] & ~w_ready;
            S_DATA:         w_stall = (r_uio[0] & ~w_ready) | (~r_uio[0] & ~src_valid_i);
            S_WAIT, S_CAP:  w_stall = ~w_hvalid;
            default:        w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_ui      <= 8'h00;
            r_uio     <= 3'b000;
            r_idx     <= '0;
            r_stall   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        r_state   <= S_CFG;
                        r_ui      <= cfg_i;
                        r_uio     <= 3'b011;
                        r_idx     <= '0;
                        r_stall   <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_CFG, S_DATA: begin
                    if (w_xfer && r_uio[2]) begin
                        r_state <= S_WAIT;
                        r_uio   <= 3'b000;
                        r_stall <= '0;
                    end else begin
                        if (w_src_hs) begin
                            r_ui  <= src_data_i;
                            r_uio <= {src_last_i, 1'b0, 1'b1};
                        end else if (w_xfer) begin
                            r_uio <= 3'b000;
                        end
                        if (r_state == S_CFG && w_xfer) begin
                            r_state <= S_DATA;
                        end
                        if (w_xfer || w_src_hs) begin
                            r_stall <= '0;
                        end else if (w_stall) begin
                            if (w_tc) begin
                                r_state   <= S_ERR;
                                r_uio     <= 3'b000;
                                r_busy    <= 1'b0;
                                r_timeout <= 1'b1;
                            end else begin
                                r_stall <= r_stall + SW'(1);
                            end
                        end
                    end
                end
                S_WAIT, S_CAP: begin
                    if (w_hvalid) begin
                        r_idx   <= r_idx + AW'(1);
                        r_stall <= '0;
                        if (r_idx == AW'(HASH_BYTES - 1)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CAP;
                        end
                    end else if (w_tc) begin
                        r_state   <= S_ERR;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_stall <= r_stall + SW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer is not reset: contents survive an abort or reset for post-mortem reads
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf[r_idx] <= uo_out_i;
        end
    end

    assign rd_data_o = r_buf[rd_addr_i];
    assign ui_in_o   = r_ui;
    assign uio_in_o  = r_uio;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;
endmodule

// File: tb/tb_blake2_host.sv
// Directed bench for blake2_host: scoreboard of bytes the core should see, plus a
// bench-side model of the hash buffer contents.
module tb_blake2_host;
    localparam int HB = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          start_i;
    logic [7:0]    cfg_i;
    logic          src_valid_i;
    logic [7:0]    src_data_i;
    logic          src_last_i;
    logic          src_ready_o;
    logic [7:0]    ui_in_o;
    logic [2:0]    uio_in_o;
    logic [7:0]    uo_out_i;
    logic [7:0]    uio_out_i;
    logic [7:0]    uio_oe_i;
    logic [4:0]    rd_addr_i;
    logic [7:0]    rd_data_o;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;

    blake2_host #(.HASH_BYTES(HB), .TIMEOUT(TO)) dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .cfg_i(cfg_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_last_i(src_last_i),
        .src_ready_o(src_ready_o), .ui_in_o(ui_in_o), .uio_in_o(uio_in_o),
        .uo_out_i(uo_out_i), .uio_out_i(uio_out_i), .uio_oe_i(uio_oe_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o),
        .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q [$];
    logic [7:0]  msg_q [$];
    logic [7:0]  model [HB];
    logic [10:0] prev_val;
    logic [7:0]  hash_base;
    bit          src_en;
    bit          last_seen;
    bit          prev_stall;
    int          ready_mode;
    int          cyc;
    int          first_x;
    int          last_x;
    int          passed;
    int          total;
    int          n;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive_src();
        src_valid_i = src_en && (msg_q.size() > 0);
        src_data_i  = (msg_q.size() > 0) ? msg_q[0] : 8'h00;
        src_last_i  = (msg_q.size() == 1);
    endtask

    // One clock: evaluate handshakes just before the edge, advance stimulus just after.
    task automatic step();
        logic       rdy;
        logic       hs;
        logic [10:0] e;
        case (ready_mode)
            0: begin uio_out_i[3] = 1'b1; uio_oe_i[3] = 1'b1; end
            1: begin
                uio_out_i[3] = (cyc % 4) != 1;
                uio_oe_i[3]  = (cyc % 4) != 3;
            end
            default: begin uio_out_i[3] = 1'b0; uio_oe_i[3] = 1'b1; end
        endcase
        @(negedge clk);
        rdy = uio_out_i[3] & uio_oe_i[3];
        hs  = src_valid_i & src_ready_o;
        if (prev_stall && busy_o)
            check("hold_stable", {uio_in_o, ui_in_o}, prev_val);
        if (uio_in_o[0] && !rdy)
            check("src_ready_low", src_ready_o, 1'b0);
        prev_stall = uio_in_o[0] & ~rdy;
        prev_val   = {uio_in_o, ui_in_o};
        if (uio_in_o[0] && rdy) begin
            check("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("core_byte", {uio_in_o, ui_in_o}, e);
            end
            if (uio_in_o[1]) first_x = cyc;
            last_x = cyc;
            if (uio_in_o[2]) last_seen = 1'b1;
        end
        if (hs) exp_q.push_back({src_last_i, 1'b0, 1'b1, src_data_i});
        @(posedge clk);
        #1;
        cyc++;
        if (hs) void'(msg_q.pop_front());
        drive_src();
    endtask

    task automatic do_start(input logic [7:0] cfg);
        start_i = 1'b1;
        cfg_i   = cfg;
        exp_q.push_back({3'b011, cfg});
        step();
        start_i = 1'b0;
        check("start_latency", {uio_in_o, ui_in_o}, {3'b011, cfg});
    endtask

    task automatic run_data();
        last_seen = 1'b0;
        for (int k = 0; k < 40 && !last_seen; k++) step();
        check("last_transfer_seen", last_seen, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("wait_outputs", {busy_o, uio_in_o}, {1'b1, 3'b000});
    endtask

    task automatic send_hash(input int gap_after, input int gap_len, input int stop_after,
                             output int ncyc);
        ncyc = 0;
        for (int i = 0; i < stop_after; i++) begin
            uo_out_i     = hash_base ^ 8'(i);
            uio_out_i[7] = 1'b1;
            step();
            ncyc++;
            model[i]  = hash_base ^ 8'(i);
            rd_addr_i = 5'(i);
            #1;
            check("rd_after_capture", rd_data_o, model[i]);
            if (i == HB - 2) check("done_not_early", done_o, 1'b0);
            if (i == HB - 1) check("done_latency", done_o, 1'b1);
            if (i == gap_after) begin
                uio_out_i[7] = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    step();
                    ncyc++;
                end
            end
        end
        uio_out_i[7] = 1'b0;
    endtask

    task automatic check_buf();
        for (int i = 0; i < HB; i++) begin
            rd_addr_i = 5'(i);
            #1;
            check("buffer", rd_data_o, model[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ui", ui_in_o, 8'h00);
        check("rst_uio", uio_in_o, 3'b000);
        check("rst_src_ready", src_ready_o, 1'b0);
        check("rst_flags", {busy_o, done_o, timeout_o}, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0; total = 0; cyc = 0; first_x = -1; last_x = -1;
        nreset = 1'b0; start_i = 1'b0; cfg_i = 8'h00;
        uo_out_i = 8'h00; uio_out_i = 8'h00; uio_oe_i = 8'hFF; rd_addr_i = '0;
        src_en = 1'b1; ready_mode = 0; prev_stall = 1'b0; prev_val = '0; hash_base = 8'h00;
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // hvalid while idle must not start anything
        uo_out_i = 8'hEE; uio_out_i[7] = 1'b1;
        step(); step();
        uio_out_i[7] = 1'b0;
        check("idle_hvalid_ignored", {busy_o, done_o}, 2'b00);

        // "abc" at full rate
        msg_q = '{8'h61, 8'h62, 8'h63};
        drive_src();
        do_start(8'h20);
        run_data();
        check("abc_back_to_back", last_x - first_x, 3);
        hash_base = 8'h00;
        send_hash(-1, 0, HB, n);
        check("abc_capture_cycles", n, HB);
        rd_addr_i = 5'd5;
        #1;
        check("abc_rd_addr5", rd_data_o, 8'h05);
        check_buf();

        // hvalid in DONE must leave the buffer alone
        uo_out_i = 8'hEE; uio_out_i[7] = 1'b1;
        step(); step();
        uio_out_i[7] = 1'b0;
        check("done_held", done_o, 1'b1);
        check_buf();

        // ready toggling, then hash with a 3-cycle hvalid gap
        ready_mode = 1;
        msg_q = '{8'h11, 8'h22, 8'h33};
        drive_src();
        do_start(8'h40);
        run_data();
        ready_mode = 0;
        hash_base = 8'hC0;
        send_hash(10, 3, HB, n);
        check("gap_capture_cycles", n, HB + 3);
        check_buf();

        // start_i and hvalid during DATA are ignored
        msg_q = '{8'h71, 8'h72};
        drive_src();
        do_start(8'h33);
        step();
        ready_mode = 2;
        uo_out_i = 8'hEE; uio_out_i[7] = 1'b1;
        start_i = 1'b1; cfg_i = 8'h99;
        step();
        start_i = 1'b0; uio_out_i[7] = 1'b0;
        check("start_ignored_in_data", {uio_in_o, ui_in_o}, {3'b001, 8'h71});
        check("busy_in_data", busy_o, 1'b1);
        ready_mode = 0;
        run_data();
        hash_base = 8'h5A;
        send_hash(-1, 0, HB, n);
        check("data_hvalid_no_shift", n, HB);
        check_buf();

        // timeout with ready held low
        ready_mode = 2;
        msg_q = '{8'h01};
        drive_src();
        do_start(8'h55);
        n = 0;
        while (!timeout_o && n < 40) begin
            step();
            n++;
        end
        check("timeout_stall_cycles", n, TO);
        check("timeout_outputs", {timeout_o, busy_o, done_o, uio_in_o, src_ready_o},
              {1'b1, 1'b0, 1'b0, 3'b000, 1'b0});
        check_buf();
        exp_q.delete();

        // recovery after timeout
        ready_mode = 0;
        msg_q = '{8'h9B};
        drive_src();
        do_start(8'h20);
        check("timeout_cleared", timeout_o, 1'b0);
        run_data();
        hash_base = 8'h3C;
        send_hash(-1, 0, HB, n);
        check_buf();

        // asynchronous reset in the middle of capture
        msg_q = '{8'hA1, 8'hA2};
        drive_src();
        do_start(8'h21);
        run_data();
        hash_base = 8'h77;
        send_hash(-1, 0, 12, n);
        #2;
        nreset = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        msg_q = '{8'hB1, 8'hB2, 8'hB3};
        drive_src();
        do_start(8'h20);
        run_data();
        hash_base = 8'h99;
        send_hash(-1, 0, HB, n);
        check("post_reset_done", done_o, 1'b1);
        check_buf();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/blake2_host.md
# blake2_host

Host-side driver for the BLAKE2 Tiny Tapeout core on the FPGA emulator, acting as the transmitting end of the core's byte-stream input protocol and the receiving end of its hash output. It takes a config byte plus a message byte stream from local logic and serialises them onto the core's `ui_in` / `uio_in[2:0]` pins under the core's ready handshake. It then captures the hash bytes the core emits on `uo_out` and exposes them through a random-access read port with done/timeout status.

## Interface
- `HASH_BYTES`, 32: number of hash bytes captured (1..64).
- `TIMEOUT`, 4096: stall cycles tolerated before abort (≥2).
- `clk` in 1: single clock.
- `nreset` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that begins a transaction; ignored unless in IDLE, DONE or ERR.
- `cfg_i` in 8: config byte, latched on accepted `start_i`.
- `src_valid_i` in 1: upstream message byte valid.
- `src_data_i` in 8: upstream message byte.
- `src_last_i` in 1: marks the final message byte.
- `src_ready_o` out 1: upstream byte accepted when `src_valid_i & src_ready_o`.
- `ui_in_o` out 8: byte presented to the core.
- `uio_in_o` out 3: to core. [0] = valid, [1] = start (config byte), [2] = last (final message byte).
- `uo_out_i` in 8: core hash byte.
- `uio_out_i` in 8: core. [3] = ready, [7] = hash_valid.
- `uio_oe_i` in 8: core output enables. Ready = `uio_out_i[3] & uio_oe_i[3]`; hvalid = `uio_out_i[7] & uio_oe_i[7]`.
- `rd_addr_i` in $clog2(HASH_BYTES): hash buffer read index.
- `rd_data_o` out 8: combinational read of the buffer at `rd_addr_i`.
- `busy_o` out 1: high in CFG, DATA, WAIT and CAP.
- `done_o` out 1: high in DONE.
- `timeout_o` out 1: high in ERR.

## Operation
- FSM states: IDLE, CFG, DATA, WAIT, CAP, DONE, ERR.
- Reset values:
  - State is IDLE.
  - `ui_in_o = 0`, `uio_in_o = 0`, `src_ready_o = 0`.
  - `busy_o`, `done_o`, `timeout_o` are 0.
  - Byte index and stall counter are 0. Hash buffer contents are undefined.
- Transfer rule: a byte moves on any cycle where `uio_in_o[0] = 1` and ready = 1. The host holds `ui_in_o` and `uio_in_o` stable until that cycle.
- IDLE/DONE/ERR + `start_i`:
  - Next cycle: `ui_in_o = cfg_i`, `uio_in_o = 3'b011`, state CFG.
  - Clear the index, stall counter, `done_o` and `timeout_o`.
- CFG, config transfer:
  - Go to DATA with `uio_in_o = 0`.
- DATA, output slot:
  - `src_ready_o = (!uio_in_o[0] | ready) & !last_sent`.
  - On an upstream handshake, load `ui_in_o = src_data_i` and `uio_in_o = {src_last_i, 1'b0, 1'b1}`.
  - A transfer with no new load clears `uio_in_o[0]`.
  - A transfer with `uio_in_o[2] = 1` moves to WAIT and drives `uio_in_o = 0`.
  - The message is ≥1 byte; an empty message is not supported.
- WAIT/CAP, capture:
  - On each cycle with hvalid, write `buf[idx] = uo_out_i` and increment `idx`. The first such cycle moves WAIT to CAP.
  - The write at `idx = HASH_BYTES-1` moves to DONE.
  - A low hvalid mid-capture stalls the capture; no byte is skipped.
  - hvalid outside WAIT/CAP is ignored and never written.
- Stall counter:
  - Increments in CFG/DATA while valid is high and ready is low.
  - Increments in DATA while the slot is empty and upstream is not valid.
  - Increments in WAIT/CAP while hvalid is low.
  - Clears on any transfer or capture.
  - Reaching `TIMEOUT-1` moves to ERR.
- ERR: `uio_in_o = 0`, `src_ready_o = 0`. Buffer contents are retained. The state is held until `start_i` or reset.
- `start_i` in CFG/DATA/WAIT/CAP is ignored.
- Reset mid-transaction returns every output to its reset value in the same cycle, since reset is asynchronous.

## Timing
- All outputs except `src_ready_o` and `rd_data_o` are registered.
- `src_ready_o` depends combinationally on the core's ready; this is the only input-to-output path besides `rd_data_o`.
- `start_i` to config byte valid: 1 cycle.
- With ready held high, throughput is 1 byte/cycle and there are no bubbles between the config byte and the message bytes.
- Last-byte transfer to WAIT: 1 cycle.
- Final hash capture to `done_o = 1`: 1 cycle.
- A buffer write is visible on `rd_data_o` the cycle after capture.

## Test plan
- Message "abc" with ready always 1 and `cfg_i = 8'h20`:
  - Core sees 0x20 (start), 0x61, 0x62, 0x63 (last=1) on 4 consecutive cycles.
  - Core then returns 32 bytes 0x00..0x1F; `done_o` rises 1 cycle after the 32nd; reading addr 5 gives 0x05.
- Ready backpressure: ready toggles 1/0 during a 3-byte message.
  - Each byte is held stable until its transfer, with no duplicates or drops.
  - `src_ready_o` is low while the slot is occupied and ready is 0.
- Hash gaps: hvalid drops for 3 cycles after byte 10.
  - The buffer holds all 32 bytes in order; `done_o` is delayed by 3 cycles.
- Timeout, with `TIMEOUT = 16`:
  - Hold ready at 0 after start; `timeout_o` is set after 16 stall cycles and `uio_in_o = 0`.
  - A new `start_i` resumes normal operation.
- Spurious and ignored inputs:
  - hvalid pulses while in IDLE or DATA write nothing.
  - `start_i` during DATA has no effect.
- Async reset: assert `nreset` in CAP at byte 12.
  - Outputs reach reset values immediately and the FSM is in IDLE.
  - A new run completes normally.
